// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control slice: state encoding,
// opcodes, ALU operation codes, trap causes and datapath selector values.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_ALU_WB   = 4'd7,
    S_I_EXEC   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam logic [1:0] SRCB_REGB    = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] REG_DST_RT = 2'd0;
  localparam logic [1:0] REG_DST_RD = 2'd1;
  localparam logic [1:0] REG_DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  // ALU operation for the immediate-arithmetic group.
  function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI: imm_alu_op = ALU_SLT;
      OP_ANDI: imm_alu_op = ALU_AND;
      OP_ORI:  imm_alu_op = ALU_OR;
      default: imm_alu_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_opcode_class.sv
// Combinational opcode classifier, shared with the pipeline decoder.
// Unknown opcodes (including X/Z) fall through to illegal.
module opcode_class
  import multicycle_control_pkg::*;
(
  input  logic [5:0] i_op,
  output logic       o_mem,
  output logic       o_rtype,
  output logic       o_imm,
  output logic       o_branch,
  output logic       o_jump,
  output logic       o_link,
  output logic       o_illegal
);

  always_comb begin
    o_mem     = 1'b0;
    o_rtype   = 1'b0;
    o_imm     = 1'b0;
    o_branch  = 1'b0;
    o_jump    = 1'b0;
    o_link    = 1'b0;
    o_illegal = 1'b0;
    case (i_op)
      OP_LW, OP_SW:                     o_mem    = 1'b1;
      OP_RTYPE:                         o_rtype  = 1'b1;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: o_imm   = 1'b1;
      OP_BEQ, OP_BNE:                   o_branch = 1'b1;
      OP_J:                             o_jump   = 1'b1;
      OP_JAL: begin
        o_jump = 1'b1;
        o_link = 1'b1;
      end
      default:                          o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM with memory handshake, bus-timeout trap
// and illegal-opcode trap. Outputs are decoded from the current state.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned ALU_OP_W    = 3,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                reg_write,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                instr_done,
  output logic                trap,
  output logic [1:0]          trap_cause
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait;
  logic [1:0]       r_cause;
  logic [1:0]       w_cause_next;
  logic [5:0]       r_op;
  logic [2:0]       w_alu3;
  logic             w_mem_state;
  logic             w_timeout;
  logic             w_mem, w_rtype, w_imm, w_branch, w_jump, w_link, w_illegal;

  opcode_class u_class (
    .i_op      (op),
    .o_mem     (w_mem),
    .o_rtype   (w_rtype),
    .o_imm     (w_imm),
    .o_branch  (w_branch),
    .o_jump    (w_jump),
    .o_link    (w_link),
    .o_illegal (w_illegal)
  );

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // mem_ready on the timeout cycle completes the access instead of trapping.
  assign w_timeout   = (MEM_TIMEOUT != 0) && w_mem_state && !mem_ready &&
                       (r_wait == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    w_next       = r_state;
    w_cause_next = r_cause;
    case (r_state)
      S_FETCH: begin
        if (w_timeout) begin
          w_next       = S_TRAP;
          w_cause_next = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_mem)         w_next = S_MEM_ADDR;
        else if (w_rtype)  w_next = S_R_EXEC;
        else if (w_imm)    w_next = S_I_EXEC;
        else if (w_branch) w_next = S_BRANCH;
        else if (w_link)   w_next = S_JAL;
        else if (w_jump)   w_next = S_JUMP;
        else begin
          w_next       = S_TRAP;
          w_cause_next = CAUSE_ILLEGAL;
        end
      end
      S_MEM_ADDR: w_next = (r_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD, S_MEM_WR: begin
        if (w_timeout) begin
          w_next       = S_TRAP;
          w_cause_next = CAUSE_TIMEOUT;
        end else if (mem_ready) begin
          w_next = (r_state == S_MEM_RD) ? S_MEM_WB : S_FETCH;
        end
      end
      S_R_EXEC: w_next = S_ALU_WB;
      S_I_EXEC: w_next = S_I_WB;
      S_MEM_WB, S_ALU_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL: w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_wait  <= '0;
      r_cause <= CAUSE_NONE;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause_next;
      if (r_state == S_DECODE) r_op <= op;
      // Non-memory states and completed accesses leave the counter at zero.
      if (w_mem_state && !mem_ready) r_wait <= r_wait + CNT_W'(1);
      else                           r_wait <= '0;
    end
  end

  assign alu_op = ALU_OP_W'(w_alu3);

  always_comb begin
    w_alu3     = ALU_ADD;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_ALU;
    reg_write  = 1'b0;
    reg_dst    = REG_DST_RT;
    mem_to_reg = M2R_ALUOUT;
    instr_done = 1'b0;
    trap       = 1'b0;
    trap_cause = CAUSE_NONE;
    if (!rst) begin
      trap_cause = r_cause;
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = SRCB_IMM_SH2;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_MDR;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          w_alu3    = ALU_FUNCT;
        end
        S_ALU_WB: begin
          reg_write  = 1'b1;
          reg_dst    = REG_DST_RD;
          instr_done = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          w_alu3    = imm_alu_op(r_op);
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a  = 1'b1;
          w_alu3     = ALU_SUB;
          pc_src     = PC_SRC_ALUOUT;
          pc_write   = (r_op == OP_BEQ) ? zero : ~zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_src     = PC_SRC_JUMP;
          pc_write   = 1'b1;
          instr_done = 1'b1;
        end
        S_JAL: begin
          pc_src     = PC_SRC_JUMP;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = REG_DST_RA;
          mem_to_reg = M2R_PC;
          instr_done = 1'b1;
        end
        S_TRAP:  trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control: per-cycle expected outputs are
// queued when inputs are driven and compared when the cycle is sampled.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic [1:0] mem_to_reg;
  logic       instr_done;
  logic       trap;
  logic [1:0] trap_cause;

  multicycle_control #(
    .ALU_OP_W    (4),
    .MEM_TIMEOUT (15),
    .CNT_W       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .instr_done (instr_done),
    .trap       (trap),
    .trap_cause (trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] aop;
    logic       sa;
    logic [1:0] sb;
    logic       iod;
    logic       mr;
    logic       mw;
    logic       irw;
    logic       pcw;
    logic [1:0] pcs;
    logic       rw;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic       done;
    logic       trp;
    logic [1:0] cause;
  } ctl_t;

  typedef struct {
    string      name;
    logic       rs;
    logic [5:0] op;
    logic       zr;
    logic       rdy;
    ctl_t       exp;
  } vec_t;

  ctl_t act;
  assign act = {alu_op, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write, ir_write,
                pc_write, pc_src, reg_write, reg_dst, mem_to_reg, instr_done, trap, trap_cause};

  int    checks   = 0;
  int    failures = 0;
  int    done_cnt = 0;
  vec_t  vecs[$];
  ctl_t  sb_q[$];
  string nm_q[$];

  ctl_t E_ZERO, E_FWAIT, E_FGO, E_DEC, E_MADDR, E_MRD, E_MWB, E_MWR_W, E_MWR_GO;
  ctl_t E_REX, E_AWB, E_IWB, E_BR_T, E_BR_N, E_JMP, E_JAL, E_TRAP1, E_TRAP2;

  localparam logic [5:0] GX = 6'b111111;

  function automatic ctl_t e_iex(input logic [3:0] aop);
    ctl_t c = '0;
    c.sa  = 1'b1;
    c.sb  = 2'd2;
    c.aop = aop;
    return c;
  endfunction

  task automatic init_expect();
    E_ZERO   = '0;
    E_FWAIT  = '0; E_FWAIT.mr = 1'b1; E_FWAIT.sb = 2'd1;
    E_FGO    = E_FWAIT; E_FGO.irw = 1'b1; E_FGO.pcw = 1'b1;
    E_DEC    = '0; E_DEC.sb = 2'd3;
    E_MADDR  = '0; E_MADDR.sa = 1'b1; E_MADDR.sb = 2'd2;
    E_MRD    = '0; E_MRD.mr = 1'b1; E_MRD.iod = 1'b1;
    E_MWB    = '0; E_MWB.rw = 1'b1; E_MWB.m2r = 2'd1; E_MWB.done = 1'b1;
    E_MWR_W  = '0; E_MWR_W.mw = 1'b1; E_MWR_W.iod = 1'b1;
    E_MWR_GO = E_MWR_W; E_MWR_GO.done = 1'b1;
    E_REX    = '0; E_REX.sa = 1'b1; E_REX.aop = 4'd2;
    E_AWB    = '0; E_AWB.rw = 1'b1; E_AWB.rd = 2'd1; E_AWB.done = 1'b1;
    E_IWB    = '0; E_IWB.rw = 1'b1; E_IWB.done = 1'b1;
    E_BR_N   = '0; E_BR_N.sa = 1'b1; E_BR_N.aop = 4'd1; E_BR_N.pcs = 2'd1; E_BR_N.done = 1'b1;
    E_BR_T   = E_BR_N; E_BR_T.pcw = 1'b1;
    E_JMP    = '0; E_JMP.pcs = 2'd2; E_JMP.pcw = 1'b1; E_JMP.done = 1'b1;
    E_JAL    = E_JMP; E_JAL.rw = 1'b1; E_JAL.rd = 2'd2; E_JAL.m2r = 2'd2;
    E_TRAP1  = '0; E_TRAP1.trp = 1'b1; E_TRAP1.cause = 2'd1;
    E_TRAP2  = '0; E_TRAP2.trp = 1'b1; E_TRAP2.cause = 2'd2;
  endtask

  task automatic add(input string n, input logic rs, input logic [5:0] o,
                     input logic zr, input logic rdy, input ctl_t e);
    vec_t v;
    v.name = n; v.rs = rs; v.op = o; v.zr = zr; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check_out();
    ctl_t  e = sb_q.pop_front();
    string n = nm_q.pop_front();
    checks++;
    if (act.done === 1'b1) done_cnt++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s: got=%h want=%h", n, act, e);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst = v.rs; op = v.op; zero = v.zr; mem_ready = v.rdy;
    sb_q.push_back(v.exp);
    nm_q.push_back(v.name);
    #2;
    check_out();
  endtask

  task automatic cmp(input string n, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got=%0d want=%0d", n, got, want);
    end
  endtask

  initial begin
    int found;
    rst = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
    init_expect();

    add("reset0", 1, GX, 0, 1, E_ZERO);
    add("reset1", 1, GX, 1, 1, E_ZERO);
    // lw with memory always ready: 5 cycles
    add("lw_fetch", 0, GX, 0, 1, E_FGO);
    add("lw_dec",   0, 6'b100011, 0, 1, E_DEC);
    add("lw_addr",  0, GX, 0, 1, E_MADDR);
    add("lw_rd",    0, GX, 0, 1, E_MRD);
    add("lw_wb",    0, GX, 0, 1, E_MWB);
    // sw with fetch stalls and 3 stall cycles on the write
    add("sw_fwait0", 0, GX, 0, 0, E_FWAIT);
    add("sw_fwait1", 0, GX, 0, 0, E_FWAIT);
    add("sw_fetch",  0, GX, 0, 1, E_FGO);
    add("sw_dec",    0, 6'b101011, 0, 1, E_DEC);
    add("sw_addr",   0, GX, 0, 1, E_MADDR);
    for (int unsigned i = 0; i < 3; i++) add("sw_wait", 0, GX, 0, 0, E_MWR_W);
    add("sw_done",   0, GX, 0, 1, E_MWR_GO);
    // R-type
    add("r_fetch", 0, GX, 0, 1, E_FGO);
    add("r_dec",   0, 6'b000000, 0, 1, E_DEC);
    add("r_exec",  0, GX, 0, 1, E_REX);
    add("r_wb",    0, GX, 0, 1, E_AWB);
    // immediate group
    add("addi_f", 0, GX, 0, 1, E_FGO); add("addi_d", 0, 6'b001000, 0, 1, E_DEC);
    add("addi_x", 0, GX, 0, 1, e_iex(4'd0)); add("addi_w", 0, GX, 0, 1, E_IWB);
    add("slti_f", 0, GX, 0, 1, E_FGO); add("slti_d", 0, 6'b001010, 0, 1, E_DEC);
    add("slti_x", 0, GX, 0, 1, e_iex(4'd5)); add("slti_w", 0, GX, 0, 1, E_IWB);
    add("andi_f", 0, GX, 0, 1, E_FGO); add("andi_d", 0, 6'b001100, 0, 1, E_DEC);
    add("andi_x", 0, GX, 0, 1, e_iex(4'd3)); add("andi_w", 0, GX, 0, 1, E_IWB);
    add("ori_f",  0, GX, 0, 1, E_FGO); add("ori_d",  0, 6'b001101, 0, 1, E_DEC);
    add("ori_x",  0, GX, 0, 1, e_iex(4'd4)); add("ori_w",  0, GX, 0, 1, E_IWB);
    // branches: 3 cycles each
    add("beq1_f", 0, GX, 0, 1, E_FGO); add("beq1_d", 0, 6'b000100, 0, 1, E_DEC);
    add("beq1_b", 0, GX, 1, 1, E_BR_T);
    add("beq0_f", 0, GX, 0, 1, E_FGO); add("beq0_d", 0, 6'b000100, 0, 1, E_DEC);
    add("beq0_b", 0, GX, 0, 1, E_BR_N);
    add("bne1_f", 0, GX, 0, 1, E_FGO); add("bne1_d", 0, 6'b000101, 0, 1, E_DEC);
    add("bne1_b", 0, GX, 1, 1, E_BR_N);
    add("bne0_f", 0, GX, 0, 1, E_FGO); add("bne0_d", 0, 6'b000101, 0, 1, E_DEC);
    add("bne0_b", 0, GX, 0, 1, E_BR_T);
    // jumps
    add("j_f",   0, GX, 0, 1, E_FGO); add("j_d",   0, 6'b000010, 0, 1, E_DEC);
    add("j_x",   0, GX, 0, 1, E_JMP);
    add("jal_f", 0, GX, 0, 1, E_FGO); add("jal_d", 0, 6'b000011, 0, 1, E_DEC);
    add("jal_x", 0, GX, 0, 1, E_JAL);
    // reset mid-sw aborts before the write strobe
    add("abort_f", 0, GX, 0, 1, E_FGO); add("abort_d", 0, 6'b101011, 0, 1, E_DEC);
    add("abort_a", 0, GX, 0, 1, E_MADDR);
    add("abort_rst", 1, GX, 0, 1, E_ZERO);
    // ready arriving on the timeout cycle completes the fetch
    for (int unsigned i = 0; i < 15; i++) add("edge_fwait", 0, GX, 0, 0, E_FWAIT);
    add("edge_fetch", 0, GX, 0, 1, E_FGO);
    add("edge_dec",   0, 6'b000010, 0, 1, E_DEC);
    add("edge_jmp",   0, GX, 0, 1, E_JMP);
    // lw stuck in MEM_RD times out
    add("tmo_f", 0, GX, 0, 1, E_FGO); add("tmo_d", 0, 6'b100011, 0, 1, E_DEC);
    add("tmo_a", 0, GX, 0, 1, E_MADDR);
    for (int unsigned i = 0; i < 16; i++) add("tmo_rdwait", 0, GX, 0, 0, E_MRD);
    add("tmo_trap0", 0, GX, 1, 1, E_TRAP2);
    add("tmo_trap1", 0, GX, 0, 0, E_TRAP2);
    add("tmo_rst",   1, GX, 0, 0, E_ZERO);
    // illegal opcode
    add("ill_f", 0, GX, 0, 1, E_FGO); add("ill_d", 0, 6'b111111, 0, 1, E_DEC);
    for (int unsigned i = 0; i < 3; i++) add("ill_trap", 0, 6'b100011, 1, 1, E_TRAP1);
    add("ill_rst", 1, GX, 0, 1, E_ZERO);
    add("ill_refetch", 0, GX, 0, 1, E_FGO);

    foreach (vecs[i]) apply(vecs[i]);
    cmp("instr_done_count", done_cnt, 14);
    cmp("scoreboard_drained", sb_q.size(), 0);

    // Fetch stuck: trap must appear once the counter reaches 15 while waiting.
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    found = -1;
    for (int k = 0; k < 40; k++) begin
      #2;
      if (trap === 1'b1) begin
        found = k;
        break;
      end
      @(negedge clk);
    end
    cmp("fetch_timeout_cycle", found, 16);
    cmp("fetch_timeout_cause", int'(trap_cause), 2);
    cmp("fetch_timeout_no_read", int'(mem_read), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
